// File: rtl/cpu_pkg.sv
// Shared types and the firmware checksum rule for the boot loader.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    WRITE    = 3'd1,
    CK_FETCH = 3'd2,
    CHECK    = 3'd3,
    RUN      = 3'd4,
    ERROR    = 3'd5
  } loader_state_e;

  // Modular sum; callers truncate to their word width, low bits stay exact.
  function automatic logic [63:0] fw_sum_step(input logic [63:0] sum, input logic [63:0] word);
    return sum + word;
  endfunction

endpackage

// File: rtl/fw_loader_if.sv
// ROM read, RAM write and core-control signals of the firmware loader.
interface fw_loader_if #(
  parameter int CPU_WIDTH = 32,
  parameter int RAM_WIDTH = 31,
  parameter int IDX_W     = 5
);
  logic [IDX_W-1:0]     rom_addr;
  logic [CPU_WIDTH-1:0] rom_data;
  logic                 ram_we;
  logic [RAM_WIDTH-1:0] ram_addr;
  logic [CPU_WIDTH-1:0] ram_wdata;
  logic                 ram_ready;
  logic                 reload;
  logic                 cpu_reset_n;
  logic                 load_done;
  logic                 load_error;

  modport master (
    output rom_addr, ram_we, ram_addr, ram_wdata, cpu_reset_n, load_done, load_error,
    input  rom_data, ram_ready, reload
  );

  modport slave (
    input  rom_addr, ram_we, ram_addr, ram_wdata, cpu_reset_n, load_done, load_error,
    output rom_data, ram_ready, reload
  );
endinterface

// File: rtl/fw_loader.sv
// Copies a firmware image from boot ROM into core RAM, verifies its checksum,
// then releases the core reset (or parks in ERROR on mismatch).
module fw_loader
  import cpu_pkg::*;
#(
  parameter int CPU_WIDTH = 32,
  parameter int RAM_WIDTH = 31,
  parameter int FW_LENGTH = 31,
  localparam int IDX_W    = $clog2(FW_LENGTH + 1)
) (
  input  logic clk,
  input  logic a_reset_n,
  fw_loader_if.master bus
);

  loader_state_e        state;
  logic [IDX_W-1:0]     idx;
  logic [CPU_WIDTH-1:0] sum;
  logic                 we_q;
  logic                 cpu_rst_n_q;
  logic                 done_q;
  logic                 err_q;

  logic [IDX_W-1:0] idx_nxt;
  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state       <= FETCH;
      idx         <= '0;
      sum         <= '0;
      we_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          state <= WRITE;
          we_q  <= 1'b1;
        end
        WRITE: begin
          // ROM address only moves on accept, so rom_data is stable through a stall.
          if (bus.ram_ready) begin
            we_q  <= 1'b0;
            sum   <= CPU_WIDTH'(fw_sum_step(64'(sum), 64'(bus.rom_data)));
            idx   <= idx_nxt;
            state <= (idx_nxt == IDX_W'(FW_LENGTH)) ? CK_FETCH : FETCH;
          end
        end
        CK_FETCH: state <= CHECK;
        CHECK: begin
          if (bus.rom_data == sum) begin
            state       <= RUN;
            cpu_rst_n_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            state <= ERROR;
            err_q <= 1'b1;
          end
        end
        RUN, ERROR: begin
          if (bus.reload) begin
            state       <= FETCH;
            idx         <= '0;
            sum         <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.rom_addr    = idx;
  assign bus.ram_addr    = RAM_WIDTH'(idx);
  assign bus.ram_we      = we_q;
  assign bus.ram_wdata   = we_q ? bus.rom_data : '0;
  assign bus.cpu_reset_n = cpu_rst_n_q;
  assign bus.load_done   = done_q;
  assign bus.load_error  = err_q;

endmodule

// File: tb/tb_fw_loader.sv
// Directed bench for fw_loader with a 4-word image and a synchronous ROM model.
module tb_fw_loader;
  localparam int CW    = 32;
  localparam int RW    = 31;
  localparam int FWL   = 4;
  localparam int IW    = $clog2(FWL + 1);

  logic clk = 1'b0;
  logic a_reset_n = 1'b0;
  always #5 clk = ~clk;

  fw_loader_if #(.CPU_WIDTH(CW), .RAM_WIDTH(RW), .IDX_W(IW)) bus ();

  fw_loader #(.CPU_WIDTH(CW), .RAM_WIDTH(RW), .FW_LENGTH(FWL)) dut (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .bus       (bus.master)
  );

  // Synchronous-read boot ROM
  logic [CW-1:0] rom [0:7];
  logic [CW-1:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  // Write log with edge numbers
  int cyc  = 0;
  int wr_n = 0;
  logic [RW-1:0] log_addr [0:63];
  logic [CW-1:0] log_data [0:63];
  int            log_edge [0:63];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we && bus.ram_ready) begin
      log_addr[wr_n % 64] <= bus.ram_addr;
      log_data[wr_n % 64] <= bus.ram_wdata;
      log_edge[wr_n % 64] <= cyc + 1;
      wr_n <= wr_n + 1;
    end
  end

  int vecs = 0;
  int errs = 0;
  int cyc_base;
  int wr_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    a_reset_n = 1'b1;
    cyc_base  = cyc;
    wr_base   = wr_n;
  endtask

  task automatic load_image(input logic [CW-1:0] w0, w1, w2, w3, ck);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = ck;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 0);
    chk({tag, "_ram_addr"}, 64'(bus.ram_addr), 0);
    chk({tag, "_ram_we"},   64'(bus.ram_we), 0);
    chk({tag, "_wdata"},    64'(bus.ram_wdata), 0);
    chk({tag, "_cpu_rst"},  64'(bus.cpu_reset_n), 0);
    chk({tag, "_done"},     64'(bus.load_done), 0);
    chk({tag, "_err"},      64'(bus.load_error), 0);
  endtask

  // Writes k=0..3 at addr k with data img[k]; edge checked when chk_edge set.
  task automatic chk_writes(input string tag, input logic [CW-1:0] w0, w1, w2, w3,
                            input bit chk_edge);
    logic [CW-1:0] img [0:3];
    img[0] = w0; img[1] = w1; img[2] = w2; img[3] = w3;
    chk({tag, "_nwrites"}, 64'(wr_n - wr_base), 4);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_waddr"}, 64'(log_addr[(wr_base + k) % 64]), 64'(k));
      chk({tag, "_wdata"}, 64'(log_data[(wr_base + k) % 64]), 64'(img[k]));
      if (chk_edge)
        chk({tag, "_wedge"}, 64'(log_edge[(wr_base + k) % 64] - cyc_base), 64'(2 * k + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = '0;
    bus.ram_ready = 1'b1;
    bus.reload    = 1'b0;

    // Nominal load, checksum 10
    load_image(1, 2, 3, 4, 10);
    step(2);
    chk_reset_vals("rst");
    release_rst();
    step(9);
    chk("nom_e9_cpu_rst", 64'(bus.cpu_reset_n), 0);
    chk("nom_e9_done", 64'(bus.load_done), 0);
    step(1);
    chk("nom_e10_cpu_rst", 64'(bus.cpu_reset_n), 1);
    chk("nom_e10_done", 64'(bus.load_done), 1);
    chk("nom_e10_err", 64'(bus.load_error), 0);
    chk_writes("nom", 1, 2, 3, 4, 1'b1);

    // Reload from RUN; a reload asserted during WRITE is ignored
    bus.reload = 1'b1;
    cyc_base = cyc; wr_base = wr_n;
    step(1);
    bus.reload = 1'b0;
    chk("rld_cpu_rst", 64'(bus.cpu_reset_n), 0);
    chk("rld_done", 64'(bus.load_done), 0);
    chk("rld_rom_addr", 64'(bus.rom_addr), 0);
    step(1);
    chk("rld_in_write", 64'(bus.ram_we), 1);
    bus.reload = 1'b1;
    step(1);
    bus.reload = 1'b0;
    chk("rld_ign_addr", 64'(bus.ram_addr), 1);
    chk("rld_ign_done", 64'(bus.load_done), 0);
    step(7);
    chk("rld_e9_done", 64'(bus.load_done), 0);
    step(1);
    chk("rld_e10_done", 64'(bus.load_done), 1);
    chk("rld_e10_cpu_rst", 64'(bus.cpu_reset_n), 1);
    chk_writes("rld", 1, 2, 3, 4, 1'b0);

    // Bad checksum parks in ERROR
    load_image(1, 2, 3, 4, 11);
    a_reset_n = 1'b0;
    #1;
    chk("bad_async_cpu_rst", 64'(bus.cpu_reset_n), 0);
    step(1);
    release_rst();
    step(10);
    chk("bad_err", 64'(bus.load_error), 1);
    chk("bad_done", 64'(bus.load_done), 0);
    chk("bad_cpu_rst", 64'(bus.cpu_reset_n), 0);
    step(20);
    chk("bad_err_hold", 64'(bus.load_error), 1);
    chk("bad_cpu_rst_hold", 64'(bus.cpu_reset_n), 0);

    // Three-cycle stall on word 2
    load_image(1, 2, 3, 4, 10);
    a_reset_n = 1'b0;
    step(1);
    release_rst();
    step(5);
    chk("stl_we", 64'(bus.ram_we), 1);
    chk("stl_addr", 64'(bus.ram_addr), 2);
    chk("stl_data", 64'(bus.ram_wdata), 3);
    bus.ram_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step(1);
      chk("stl_hold_we", 64'(bus.ram_we), 1);
      chk("stl_hold_addr", 64'(bus.ram_addr), 2);
      chk("stl_hold_rom", 64'(bus.rom_addr), 2);
      chk("stl_hold_data", 64'(bus.ram_wdata), 3);
    end
    bus.ram_ready = 1'b1;
    step(1);
    chk("stl_acc_we", 64'(bus.ram_we), 0);
    chk("stl_acc_addr", 64'(bus.ram_addr), 3);
    step(3);
    chk("stl_e12_done", 64'(bus.load_done), 0);
    step(1);
    chk("stl_e13_done", 64'(bus.load_done), 1);
    chk_writes("stl", 1, 2, 3, 4, 1'b0);

    // Checksum wraps modulo 2^32
    load_image(32'hFFFF_FFFF, 2, 0, 0, 1);
    a_reset_n = 1'b0;
    step(1);
    release_rst();
    step(10);
    chk("wrap_done", 64'(bus.load_done), 1);
    chk("wrap_err", 64'(bus.load_error), 0);
    chk_writes("wrap", 32'hFFFF_FFFF, 2, 0, 0, 1'b1);

    // Async reset mid-write of word 2, then a clean restart
    load_image(1, 2, 3, 4, 10);
    a_reset_n = 1'b0;
    step(1);
    release_rst();
    step(5);
    chk("mid_pre_we", 64'(bus.ram_we), 1);
    #2;
    a_reset_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    step(1);
    release_rst();
    step(10);
    chk("mid_done", 64'(bus.load_done), 1);
    chk("mid_cpu_rst", 64'(bus.cpu_reset_n), 1);
    chk_writes("mid", 1, 2, 3, 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fw_loader.md
# fw_loader

Boot-time firmware loader sitting directly upstream of the `cpu` core. After reset, it copies `FW_LENGTH` words from a synchronous boot ROM into the core's instruction/data RAM write port, then verifies a modular checksum word. It releases the core's reset only if the checksum matches; otherwise it parks in an error state. A `reload` pulse repeats the whole sequence without a global reset.

## Interface
- `CPU_WIDTH`, 32, data word width in bits.
- `RAM_WIDTH`, 31, RAM word-address width in bits.
- `FW_LENGTH`, 31, number of firmware words; must be ≥ 1.
- `IDX_W` (localparam), $clog2(FW_LENGTH+1), word-index / ROM address width.

Clocking and reset (already decided): one clock `clk`; reset `a_reset_n`, asynchronous, active-low.

- `clk`  in  1  system clock.
- `a_reset_n`  in  1  asynchronous active-low reset.
- `rom_addr`  out  IDX_W  ROM word address; registered index.
- `rom_data`  in  CPU_WIDTH  ROM read data; valid one cycle after `rom_addr` is presented.
- `ram_we`  out  1  RAM write request.
- `ram_addr`  out  RAM_WIDTH  write word address; index zero-extended.
- `ram_wdata`  out  CPU_WIDTH  write data; `rom_data` while `ram_we`=1, else 0.
- `ram_ready`  in  1  RAM accepts the write this cycle.
- `reload`  in  1  single-cycle request to re-run the load.
- `cpu_reset_n`  out  1  active-low reset to the core.
- `load_done`  out  1  load finished and checksum matched.
- `load_error`  out  1  checksum mismatch.

## Operation
- ROM layout: words 0..FW_LENGTH-1 hold the firmware image; word FW_LENGTH holds the checksum, which is the sum of all image words mod 2^CPU_WIDTH.
- States:
  - FETCH: 1 cycle; covers ROM latency; → WRITE.
  - WRITE: `ram_we`=1, holding address and data until `ram_ready`=1. On accept: `sum += rom_data`, `idx++`. If the new idx = FW_LENGTH → CK_FETCH, else → FETCH.
  - CK_FETCH: 1 cycle, `rom_addr`=FW_LENGTH; → CHECK.
  - CHECK: compare `rom_data` against `sum`. Equal → RUN; not equal → ERROR.
  - RUN: `cpu_reset_n`=1, `load_done`=1.
  - ERROR: `cpu_reset_n`=0, `load_error`=1.
- `reload`=1 in RUN or ERROR → FETCH with idx=0, sum=0. `cpu_reset_n`, `load_done` and `load_error` all go to 0 on the same edge.
- `reload` is ignored in FETCH, WRITE, CK_FETCH and CHECK.
- `rom_addr` and `ram_addr` change only on an accepted write or on a reset/reload. They are stable for the whole WRITE hold.
- Sum arithmetic is CPU_WIDTH bits and wraps silently.

## Timing
- Reset values: state FETCH, idx 0, sum 0, `rom_addr` 0, `ram_addr` 0, `ram_we` 0, `ram_wdata` 0, `cpu_reset_n` 0, `load_done` 0, `load_error` 0.
- Assertion of `a_reset_n` mid-load aborts immediately and asynchronously. The load restarts from word 0 after release.
- All outputs are registered except `ram_wdata`, which is a gated `rom_data`.
- With `ram_ready` tied to 1, each word takes 2 cycles.
  - Word k is written on edge 2k+2, counting edge 1 as the first edge after reset release.
  - `cpu_reset_n`/`load_done` rise after edge 2·FW_LENGTH+2, i.e. edge 64 for the defaults.
- Each cycle `ram_ready`=0 during WRITE adds one cycle. A write is never dropped or duplicated.
- `ram_we`=1 && `ram_ready`=1 on the same edge as `a_reset_n` assertion: the write counts as not accepted.

## Structure
- `cpu_pkg` holds:
  - `loader_state_e` (FETCH, WRITE, CK_FETCH, CHECK, RUN, ERROR);
  - the checksum rule, as function `fw_sum_step(sum, word)`.
- Single module. The ROM model (`fw_rom`, $readmemh-backed, synchronous read) is bench-only and is not part of the RTL.

## Test plan
- FW_LENGTH=4, image {1,2,3,4}, checksum 10, `ram_ready`=1 → writes at addr 0..3 on edges 2,4,6,8; `cpu_reset_n`=1 and `load_done`=1 after edge 10.
- Same image with checksum 11 → `load_error`=1 after edge 10; `cpu_reset_n` stays 0 forever.
- `ram_ready` low for 3 cycles on word 2 → `ram_we`, addr 2 and data 3 held stable; exactly 4 writes occur; done after edge 13.
- Image {0xFFFFFFFF, 2}, checksum 1 → wrap accepted, `load_done`=1.
- `a_reset_n` pulsed low during word 2 → outputs return to reset values at once; the reload restarts at addr 0 and completes normally.
- `reload` in RUN → `cpu_reset_n` falls on the next edge; full reload completes. `reload` during WRITE → no effect.
